// File: rtl/cpu_pkg.sv
// Shared CPU-wide types and default bus widths used by control, register file
// and the memory bus controller.
package cpu_pkg;

  localparam int CPU_DATA_W = 32;
  localparam int CPU_ADDR_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DONE
  } mem_state_e;

endpackage

// File: rtl/mem_ctrl_wait_timer.sv
// Saturating wait counter; tc flags the cycle whose un-acked edge would
// bring the count up to TIMEOUT.
module wait_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int W = $clog2(TIMEOUT + 1);
  localparam logic [W-1:0] LIMIT = W'(TIMEOUT);
  localparam logic [W-1:0] LAST  = W'(TIMEOUT - 1);

  logic [W-1:0] count;

  // Clear wins over enable; the count stops at LIMIT instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && count != LIMIT) begin
      count <= count + 1'b1;
    end
  end

  assign tc = (count == LAST);

endmodule

// File: rtl/mem_ctrl.sv
// Memory bus controller: converts held mem_rd/mem_wr strobes into a req/ack
// transaction with a four-phase done handshake and a bounded wait.
module mem_ctrl
  import cpu_pkg::*;
#(
  parameter int DATA_W  = CPU_DATA_W,
  parameter int ADDR_W  = CPU_ADDR_W,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_rd,
  input  logic              mem_wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_ack
);

  mem_state_e state;
  logic       timer_tc;

  wait_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_wait_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (state != REQ),
    .en   ((state == REQ) && !m_ack),
    .tc   (timer_tc)
  );

  // Every output is a register updated alongside the state, so no input
  // reaches an output combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      rdata   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      m_req   <= 1'b0;
      m_we    <= 1'b0;
      m_addr  <= '0;
      m_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_rd ^ mem_wr) begin
            m_addr  <= addr;
            m_wdata <= wdata;
            m_we    <= mem_wr;
            err     <= 1'b0;
            m_req   <= 1'b1;
            busy    <= 1'b1;
            state   <= REQ;
          end else if (mem_rd && mem_wr) begin
            err   <= 1'b1;
            done  <= 1'b1;
            busy  <= 1'b1;
            state <= DONE;
          end
        end
        REQ: begin
          // An ack on the expiring edge still completes cleanly.
          if (m_ack) begin
            if (!m_we) rdata <= m_rdata;
            m_req <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else if (timer_tc) begin
            err   <= 1'b1;
            m_req <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          if (!mem_rd && !mem_wr) begin
            done  <= 1'b0;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          m_req <= 1'b0;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed, table-driven bench for mem_ctrl with a short wait limit so the
// timeout and ack-at-limit corners are reachable in a few cycles.
module tb_mem_ctrl;

  localparam int DW = 32;
  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          mem_rd = 1'b0;
  logic          mem_wr = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] wdata = '0;
  logic [DW-1:0] rdata;
  logic          busy;
  logic          done;
  logic          err;
  logic          m_req;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_rdata = '0;
  logic          m_ack = 1'b0;

  int checks = 0;
  int failures = 0;

  mem_ctrl #(
    .DATA_W (DW),
    .ADDR_W (AW),
    .TIMEOUT(4)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .mem_rd (mem_rd),
    .mem_wr (mem_wr),
    .addr   (addr),
    .wdata  (wdata),
    .rdata  (rdata),
    .busy   (busy),
    .done   (done),
    .err    (err),
    .m_req  (m_req),
    .m_we   (m_we),
    .m_addr (m_addr),
    .m_wdata(m_wdata),
    .m_rdata(m_rdata),
    .m_ack  (m_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          rd;
    logic          wr;
    logic [AW-1:0] a;
    logic [DW-1:0] wd;
    logic          ack;
    logic [DW-1:0] mrd;
    logic          e_req;
    logic          e_done;
    logic          e_err;
    logic          e_busy;
    logic          e_we;
    logic [DW-1:0] e_rdata;
    logic [AW-1:0] e_maddr;
    logic [DW-1:0] e_mwdata;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic rd, input logic wr, input logic [AW-1:0] a,
                              input logic [DW-1:0] wd, input logic ack, input logic [DW-1:0] mrd,
                              input logic e_req, input logic e_done, input logic e_err,
                              input logic e_busy, input logic e_we, input logic [DW-1:0] e_rdata,
                              input logic [AW-1:0] e_maddr, input logic [DW-1:0] e_mwdata);
    vec_t v;
    v.rd = rd; v.wr = wr; v.a = a; v.wd = wd; v.ack = ack; v.mrd = mrd;
    v.e_req = e_req; v.e_done = e_done; v.e_err = e_err; v.e_busy = e_busy;
    v.e_we = e_we; v.e_rdata = e_rdata; v.e_maddr = e_maddr; v.e_mwdata = e_mwdata;
    vecs.push_back(v);
  endfunction

  task automatic check_output(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input vec_t v);
    mem_rd  = v.rd;
    mem_wr  = v.wr;
    addr    = v.a;
    wdata   = v.wd;
    m_ack   = v.ack;
    m_rdata = v.mrd;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int req_cycles;

    // rd wr addr wdata ack mrdata | req done err busy we rdata m_addr m_wdata
    add(1,0,16'h0010,0,0,0,                    1,0,0,1,0,32'h0,16'h0010,0);
    add(1,0,16'h0010,0,1,32'hDEADBEEF,         0,1,0,1,0,32'hDEADBEEF,16'h0010,0);
    add(0,0,16'h0000,0,0,0,                    0,0,0,0,0,32'hDEADBEEF,16'h0010,0);
    add(0,1,16'h0020,32'h12345678,0,0,         1,0,0,1,1,32'hDEADBEEF,16'h0020,32'h12345678);
    add(0,1,16'hFFFF,0,0,0,                    1,0,0,1,1,32'hDEADBEEF,16'h0020,32'h12345678);
    add(0,1,16'hFFFF,0,0,0,                    1,0,0,1,1,32'hDEADBEEF,16'h0020,32'h12345678);
    add(0,1,16'hFFFF,0,0,0,                    1,0,0,1,1,32'hDEADBEEF,16'h0020,32'h12345678);
    add(0,1,16'hFFFF,0,1,32'hAAAA5555,         0,1,0,1,1,32'hDEADBEEF,16'h0020,32'h12345678);
    add(0,0,16'h0000,0,0,0,                    0,0,0,0,1,32'hDEADBEEF,16'h0020,32'h12345678);
    add(1,0,16'h0030,0,0,0,                    1,0,0,1,0,32'hDEADBEEF,16'h0030,0);
    add(1,0,16'h0030,0,0,0,                    1,0,0,1,0,32'hDEADBEEF,16'h0030,0);
    add(1,0,16'h0030,0,0,0,                    1,0,0,1,0,32'hDEADBEEF,16'h0030,0);
    add(1,0,16'h0030,0,0,0,                    1,0,0,1,0,32'hDEADBEEF,16'h0030,0);
    add(1,0,16'h0030,0,0,0,                    0,1,1,1,0,32'hDEADBEEF,16'h0030,0);
    add(1,0,16'h0030,0,0,0,                    0,1,1,1,0,32'hDEADBEEF,16'h0030,0);
    add(0,0,16'h0000,0,0,0,                    0,0,1,0,0,32'hDEADBEEF,16'h0030,0);
    add(1,0,16'h0040,0,0,0,                    1,0,0,1,0,32'hDEADBEEF,16'h0040,0);
    add(1,0,16'h0040,0,0,0,                    1,0,0,1,0,32'hDEADBEEF,16'h0040,0);
    add(1,0,16'h0040,0,0,0,                    1,0,0,1,0,32'hDEADBEEF,16'h0040,0);
    add(1,0,16'h0040,0,0,0,                    1,0,0,1,0,32'hDEADBEEF,16'h0040,0);
    add(1,0,16'h0040,0,1,32'hCAFEF00D,         0,1,0,1,0,32'hCAFEF00D,16'h0040,0);
    add(0,0,16'h0000,0,0,0,                    0,0,0,0,0,32'hCAFEF00D,16'h0040,0);
    add(1,1,16'h7777,32'h99999999,0,0,         0,1,1,1,0,32'hCAFEF00D,16'h0040,0);
    add(1,0,16'h7777,0,0,0,                    0,1,1,1,0,32'hCAFEF00D,16'h0040,0);
    add(0,0,16'h0000,0,0,0,                    0,0,1,0,0,32'hCAFEF00D,16'h0040,0);

    repeat (2) @(posedge clk);
    #1;
    check_output("rst.req",   32'(m_req),  0);
    check_output("rst.busy",  32'(busy),   0);
    check_output("rst.done",  32'(done),   0);
    check_output("rst.err",   32'(err),    0);
    check_output("rst.we",    32'(m_we),   0);
    check_output("rst.rdata", rdata,       0);
    check_output("rst.maddr", 32'(m_addr), 0);
    check_output("rst.mwdata", m_wdata,    0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < vecs.size(); i++) begin
      apply_stimulus(vecs[i]);
      check_output($sformatf("v%0d.req", i),    32'(m_req),   32'(vecs[i].e_req));
      check_output($sformatf("v%0d.done", i),   32'(done),    32'(vecs[i].e_done));
      check_output($sformatf("v%0d.err", i),    32'(err),     32'(vecs[i].e_err));
      check_output($sformatf("v%0d.busy", i),   32'(busy),    32'(vecs[i].e_busy));
      check_output($sformatf("v%0d.we", i),     32'(m_we),    32'(vecs[i].e_we));
      check_output($sformatf("v%0d.rdata", i),  rdata,        vecs[i].e_rdata);
      check_output($sformatf("v%0d.maddr", i),  32'(m_addr),  32'(vecs[i].e_maddr));
      check_output($sformatf("v%0d.mwdata", i), m_wdata,      vecs[i].e_mwdata);
    end

    // Held read: one req pulse, done held while the strobe stays up, and a
    // stray ack while in DONE must not disturb rdata.
    req_cycles = 0;
    mem_rd = 1'b1;
    mem_wr = 1'b0;
    addr = 16'h0050;
    for (int i = 0; i < 8; i++) begin
      m_ack = (i >= 2) || m_req;
      m_rdata = (i >= 2) ? 32'h55550000 : 32'h11112222;
      @(posedge clk);
      #1;
      if (m_req) req_cycles++;
    end
    check_output("held.req_cycles", 32'(req_cycles), 1);
    check_output("held.done", 32'(done), 1);
    check_output("held.rdata", rdata, 32'h11112222);
    mem_rd = 1'b0;
    m_ack = 1'b0;
    @(posedge clk);
    #1;
    check_output("held.release_done", 32'(done), 0);
    check_output("held.release_busy", 32'(busy), 0);

    // Asynchronous reset while waiting for an ack.
    mem_rd = 1'b1;
    addr = 16'h0060;
    repeat (2) @(posedge clk);
    #1;
    check_output("arst.pre_req", 32'(m_req), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("arst.req",   32'(m_req),  0);
    check_output("arst.busy",  32'(busy),   0);
    check_output("arst.done",  32'(done),   0);
    check_output("arst.rdata", rdata,       0);
    check_output("arst.maddr", 32'(m_addr), 0);
    mem_rd = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_output("arst.idle_req", 32'(m_req), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
